// File: rtl/lpddr3_lane_tx_ctrl_pkg.sv
// Shared types and defaults for the LPDDR3 byte-lane transmit controller.
// Holds the delay sequencer state enum, parameter defaults and the OE width helper.
package lpddr3_lane_pkg;

    localparam int GEAR_DEF     = 8;
    localparam int DLY_W_DEF    = 8;
    localparam int MAX_TAP_DEF  = 255;
    localparam int INIT_TAP_DEF = 1;
    localparam int STEP_GAP_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MOVE,
        S_GAP,
        S_DONE,
        S_ERR
    } dly_state_t;

    // OE bus is half the TX gearing per channel
    function automatic int oe_w(input int gear);
        return gear / 2;
    endfunction

endpackage

// File: rtl/lpddr3_lane_tx_ctrl_if.sv
// Lane bus: write beats, TX/OE gearbox outputs, delay requests and IOD delay controls.
// slave = controller side, master = fabric/IOD side.
interface lpddr3_lane_tx_ctrl_if
    import lpddr3_lane_pkg::*;
#(
    parameter int NUM_CH = 9,
    parameter int GEAR   = GEAR_DEF,
    parameter int DLY_W  = DLY_W_DEF,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);

    logic                          wr_valid;
    logic [NUM_CH*GEAR-1:0]        wr_data;
    logic [NUM_CH*GEAR-1:0]        tx_data;
    logic [NUM_CH*oe_w(GEAR)-1:0]  oe_data;

    logic                          dly_req;
    logic                          dly_load;
    logic [CH_W-1:0]               dly_ch;
    logic [DLY_W-1:0]              dly_target;
    logic                          dly_ready;
    logic                          dly_done;
    logic                          dly_err;
    logic [DLY_W-1:0]              dly_cur;

    logic [NUM_CH-1:0]             delay_line_move;
    logic [NUM_CH-1:0]             delay_line_direction;
    logic [NUM_CH-1:0]             delay_line_load;
    logic [NUM_CH-1:0]             delay_line_out_of_range;

    modport slave (
        input  wr_valid, wr_data, dly_req, dly_load, dly_ch, dly_target,
        input  delay_line_out_of_range,
        output tx_data, oe_data, dly_ready, dly_done, dly_err, dly_cur,
        output delay_line_move, delay_line_direction, delay_line_load
    );

    modport master (
        output wr_valid, wr_data, dly_req, dly_load, dly_ch, dly_target,
        output delay_line_out_of_range,
        input  tx_data, oe_data, dly_ready, dly_done, dly_err, dly_cur,
        input  delay_line_move, delay_line_direction, delay_line_load
    );

endinterface

// File: rtl/lpddr3_lane_tx_ctrl_lane_dly_seq.sv
// Per-channel output delay sequencer: steps/loads IOD delay lines and tracks tap codes.
// Ports: clk/rst, request (req/load/ch/target), status (ready/done/err/cur), IOD controls.
module lane_dly_seq
    import lpddr3_lane_pkg::*;
#(
    parameter int NUM_CH   = 9,
    parameter int DLY_W    = DLY_W_DEF,
    parameter int MAX_TAP  = MAX_TAP_DEF,
    parameter int INIT_TAP = INIT_TAP_DEF,
    parameter int STEP_GAP = STEP_GAP_DEF,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              load,
    input  logic [CH_W-1:0]   ch,
    input  logic [DLY_W-1:0]  target,
    input  logic [NUM_CH-1:0] oor,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [DLY_W-1:0]  cur,
    output logic [NUM_CH-1:0] dl_move,
    output logic [NUM_CH-1:0] dl_dir,
    output logic [NUM_CH-1:0] dl_load
);

    localparam int GW = (STEP_GAP > 2) ? $clog2(STEP_GAP) : 1;
    localparam logic [GW-1:0]    GAP_LAST = GW'(STEP_GAP - 2);
    localparam logic [DLY_W-1:0] TAP_MAX  = DLY_W'(MAX_TAP);
    localparam logic [DLY_W-1:0] TAP_INIT = DLY_W'(INIT_TAP);

    dly_state_t        state, state_nx;
    logic [CH_W-1:0]   ch_q;
    logic [DLY_W-1:0]  tgt_q;
    logic              dir_q;
    logic [GW-1:0]     gap_q;
    logic [DLY_W-1:0]  code [NUM_CH];
    logic [DLY_W-1:0]  code_q;
    logic [NUM_CH-1:0] sel;
    logic              tgt_ovf;

    // only build the range check when the code width can exceed MAX_TAP
    if (MAX_TAP < (2 ** DLY_W) - 1) begin : g_ovf
        assign tgt_ovf = target > TAP_MAX;
    end else begin : g_no_ovf
        assign tgt_ovf = 1'b0;
    end

    always_comb begin
        cur    = '0;
        code_q = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch == CH_W'(c))   cur    = code[c];
            if (ch_q == CH_W'(c)) code_q = code[c];
        end
    end

    assign sel = NUM_CH'(1) << ch_q;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (req) begin
                    if (load)              state_nx = S_LOAD;
                    else if (tgt_ovf)      state_nx = S_ERR;
                    else if (target == cur) state_nx = S_DONE;
                    else                   state_nx = S_MOVE;
                end
            end
            S_LOAD: state_nx = S_DONE;
            S_MOVE: state_nx = S_GAP;
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (|(oor & sel))         state_nx = S_ERR;
                    else if (code_q == tgt_q) state_nx = S_DONE;
                    else                      state_nx = S_MOVE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ch_q  <= '0;
            tgt_q <= '0;
            dir_q <= 1'b0;
            gap_q <= '0;
            err   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) code[c] <= TAP_INIT;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && req) begin
                ch_q  <= ch;
                tgt_q <= target;
                dir_q <= !load && (target > cur);
                err   <= 1'b0;
            end
            if (state == S_ERR) err <= 1'b1;
            if (state == S_MOVE)     gap_q <= '0;
            else if (state == S_GAP) gap_q <= gap_q + 1'b1;
            // tracker saturates at both ends instead of wrapping
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_q == CH_W'(c)) begin
                    if (state == S_LOAD) begin
                        code[c] <= TAP_INIT;
                    end else if (state == S_MOVE) begin
                        if (dir_q && code[c] != TAP_MAX)
                            code[c] <= code[c] + 1'b1;
                        else if (!dir_q && code[c] != '0)
                            code[c] <= code[c] - 1'b1;
                    end
                end
            end
        end
    end

    assign ready   = (state == S_IDLE);
    assign done    = (state == S_DONE);
    assign dl_move = (state == S_MOVE) ? sel : '0;
    assign dl_load = (state == S_LOAD) ? sel : '0;
    assign dl_dir  = (state != S_IDLE && dir_q) ? sel : '0;

endmodule

// File: rtl/lpddr3_lane_tx_ctrl.sv
// LPDDR3 byte-lane TX controller: write pipeline with OE pre/postamble plus delay sequencer.
// Ports: fab_clk, tx_sync_rst (sync, active high), bus (lane interface, slave side).
module lpddr3_lane_tx_ctrl
    import lpddr3_lane_pkg::*;
#(
    parameter int NUM_CH   = 9,
    parameter int GEAR     = GEAR_DEF,
    parameter int DLY_W    = DLY_W_DEF,
    parameter int MAX_TAP  = MAX_TAP_DEF,
    parameter int INIT_TAP = INIT_TAP_DEF,
    parameter int STEP_GAP = STEP_GAP_DEF
) (
    input  logic                   fab_clk,
    input  logic                   tx_sync_rst,
    lpddr3_lane_tx_ctrl_if.slave   bus
);

    localparam int DW = NUM_CH * GEAR;
    localparam int OW = NUM_CH * oe_w(GEAR);

    logic          v1, v2, v3;
    logic [DW-1:0] d1, d2;
    logic [DW-1:0] tx_q;
    logic [OW-1:0] oe_q;

    // v1 gives the preamble cycle, v3 the postamble cycle
    always_ff @(posedge fab_clk) begin
        if (tx_sync_rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            d1   <= '0;
            d2   <= '0;
            tx_q <= '0;
            oe_q <= '0;
        end else begin
            v1   <= bus.wr_valid;
            d1   <= bus.wr_data;
            v2   <= v1;
            d2   <= d1;
            v3   <= v2;
            tx_q <= v2 ? d2 : '0;
            oe_q <= {OW{v1 | v2 | v3}};
        end
    end

    assign bus.tx_data = tx_q;
    assign bus.oe_data = oe_q;

    lane_dly_seq #(
        .NUM_CH   (NUM_CH),
        .DLY_W    (DLY_W),
        .MAX_TAP  (MAX_TAP),
        .INIT_TAP (INIT_TAP),
        .STEP_GAP (STEP_GAP)
    ) u_seq (
        .clk     (fab_clk),
        .rst     (tx_sync_rst),
        .req     (bus.dly_req),
        .load    (bus.dly_load),
        .ch      (bus.dly_ch),
        .target  (bus.dly_target),
        .oor     (bus.delay_line_out_of_range),
        .ready   (bus.dly_ready),
        .done    (bus.dly_done),
        .err     (bus.dly_err),
        .cur     (bus.dly_cur),
        .dl_move (bus.delay_line_move),
        .dl_dir  (bus.delay_line_direction),
        .dl_load (bus.delay_line_load)
    );

endmodule

// File: tb/tb_lpddr3_lane_tx_ctrl.sv
// Directed bench for lpddr3_lane_tx_ctrl: write path timing and delay sequencer.
// Tap codes are 9 bits wide so a target above MAX_TAP (300) can be presented.
module tb_lpddr3_lane_tx_ctrl;

    localparam int NCH = 9;
    localparam int GR  = 8;
    localparam int DW  = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int np, nl, t_done, t_end, gap_bad, dir_bad, other;
    logic [71:0] beat0, beat1;
    logic [DW-1:0] cv;
    int cnt;

    localparam logic [71:0] OE_ON = 72'({36{1'b1}});

    lpddr3_lane_tx_ctrl_if #(.NUM_CH(NCH), .GEAR(GR), .DLY_W(DW)) bus ();

    lpddr3_lane_tx_ctrl #(
        .NUM_CH(NCH), .GEAR(GR), .DLY_W(DW),
        .MAX_TAP(255), .INIT_TAP(1), .STEP_GAP(4)
    ) dut (
        .fab_clk     (clk),
        .tx_sync_rst (rst),
        .bus         (bus)
    );

    task automatic check(input string tag, input logic [71:0] obs,
                         input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cur_of(input int c, output logic [DW-1:0] v);
        bus.dly_ch = 4'(c);
        #1;
        v = bus.dly_cur;
    endtask

    // issue one request and follow it until the sequencer is idle again
    task automatic run_req(input logic ld, input int ch, input int tgt,
                           input logic exp_dir, input int oor_after,
                           input int busy_at);
        logic [NCH-1:0] sel;
        int last;
        sel = '0;
        sel[ch] = 1'b1;
        np = 0; nl = 0; t_done = -1; t_end = -1;
        gap_bad = 0; dir_bad = 0; other = 0; last = 0;
        bus.dly_req    = 1'b1;
        bus.dly_load   = ld;
        bus.dly_ch     = 4'(ch);
        bus.dly_target = 9'(tgt);
        @(negedge clk);
        bus.dly_req = 1'b0;
        for (int t = 1; t <= 200; t++) begin
            if (t == busy_at + 1) bus.dly_req = 1'b0;
            if (t == busy_at) begin
                bus.dly_req    = 1'b1;
                bus.dly_load   = 1'b0;
                bus.dly_ch     = 4'd5;
                bus.dly_target = 9'd9;
            end
            if (bus.delay_line_move[ch]) begin
                np++;
                if (np > 1 && t - last != 4) gap_bad++;
                last = t;
                if (bus.delay_line_direction[ch] !== exp_dir) dir_bad++;
                if (np == oor_after) bus.delay_line_out_of_range[ch] = 1'b1;
            end
            if (bus.delay_line_load[ch]) nl++;
            if (|((bus.delay_line_move | bus.delay_line_load |
                   bus.delay_line_direction) & ~sel)) other++;
            if (bus.dly_done && t_done < 0) t_done = t;
            if (bus.dly_ready) begin
                t_end = t;
                break;
            end
            @(negedge clk);
        end
        bus.dly_req = 1'b0;
        bus.delay_line_out_of_range = '0;
        bus.dly_ch = 4'(ch);
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.dly_req  = 1'b0;
        bus.dly_load = 1'b0;
        bus.dly_ch   = '0;
        bus.dly_target = '0;
        bus.delay_line_out_of_range = '0;

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", bus.tx_data, 72'd0);
        check("rst_oe", 72'(bus.oe_data), 72'd0);
        check("rst_dl", 72'({bus.delay_line_move, bus.delay_line_direction,
                             bus.delay_line_load}), 72'd0);
        check("rst_done_err", 72'({bus.dly_done, bus.dly_err}), 72'd0);
        check("rst_ready", 72'(bus.dly_ready), 72'd1);
        for (int c = 0; c < NCH; c++) begin
            cur_of(c, cv);
            check($sformatf("rst_cur%0d", c), 72'(cv), 72'd1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // single beat: OE n+1..n+3, data only at n+2
        beat0 = {8'h99, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'hA5};
        bus.wr_valid = 1'b1;
        bus.wr_data  = beat0;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        for (int t = 0; t <= 5; t++) begin
            check($sformatf("beat_oe_t%0d", t), 72'(bus.oe_data),
                  (t >= 1 && t <= 3) ? OE_ON : 72'd0);
            check($sformatf("beat_tx_t%0d", t), bus.tx_data,
                  (t == 2) ? beat0 : 72'd0);
            @(negedge clk);
        end

        // two beats one idle cycle apart: OE stays high throughout
        beat1 = {8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78, 8'h5A};
        bus.wr_valid = 1'b1;
        bus.wr_data  = beat0;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        check("b2b_oe_t0", 72'(bus.oe_data), 72'd0);
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_data  = beat1;
        check("b2b_oe_t1", 72'(bus.oe_data), OE_ON);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        check("b2b_oe_t2", 72'(bus.oe_data), OE_ON);
        check("b2b_tx_t2", bus.tx_data, beat0);
        @(negedge clk);
        check("b2b_oe_t3", 72'(bus.oe_data), OE_ON);
        check("b2b_tx_t3", bus.tx_data, 72'd0);
        @(negedge clk);
        check("b2b_oe_t4", 72'(bus.oe_data), OE_ON);
        check("b2b_tx_t4", bus.tx_data, beat1);
        @(negedge clk);
        check("b2b_oe_t5", 72'(bus.oe_data), OE_ON);
        @(negedge clk);
        check("b2b_oe_t6", 72'(bus.oe_data), 72'd0);

        // move up: ch8 1 -> 5
        run_req(1'b0, 8, 5, 1'b1, 0, -10);
        check("up_pulses", 72'(np), 72'd4);
        check("up_gap", 72'(gap_bad), 72'd0);
        check("up_dir", 72'(dir_bad), 72'd0);
        check("up_done_t", 72'(t_done), 72'd17);
        check("up_other", 72'(other), 72'd0);
        cur_of(8, cv);
        check("up_cur", 72'(cv), 72'd5);

        // move down: ch8 5 -> 2
        run_req(1'b0, 8, 2, 1'b0, 0, -10);
        check("dn_pulses", 72'(np), 72'd3);
        check("dn_dir", 72'(dir_bad), 72'd0);
        check("dn_done_t", 72'(t_done), 72'd13);
        cur_of(8, cv);
        check("dn_cur", 72'(cv), 72'd2);

        // load ch8
        run_req(1'b1, 8, 77, 1'b0, 0, -10);
        check("ld_loads", 72'(nl), 72'd1);
        check("ld_moves", 72'(np), 72'd0);
        check("ld_done", 72'(t_done > 0), 72'd1);
        cur_of(8, cv);
        check("ld_cur", 72'(cv), 72'd1);

        // out of range raised after the 2nd step toward 10 on ch3
        run_req(1'b0, 3, 10, 1'b1, 2, -10);
        check("oor_pulses", 72'(np), 72'd2);
        check("oor_err", 72'(bus.dly_err), 72'd1);
        check("oor_nodone", 72'(t_done), 72'hFF_FFFF_FFFF_FFFF_FFFF);
        cur_of(3, cv);
        check("oor_cur", 72'(cv), 72'd3);

        // zero-step request clears the sticky error
        run_req(1'b0, 3, 3, 1'b0, 0, -10);
        check("clr_err", 72'(bus.dly_err), 72'd0);
        check("zero_pulses", 72'(np), 72'd0);
        check("zero_done", 72'(t_done > 0), 72'd1);

        // target above MAX_TAP: immediate error, no pulses
        run_req(1'b0, 1, 300, 1'b0, 0, -10);
        check("big_pulses", 72'(np + nl), 72'd0);
        check("big_err", 72'(bus.dly_err), 72'd1);
        check("big_end_t", 72'(t_end), 72'd2);
        cur_of(1, cv);
        check("big_cur", 72'(cv), 72'd1);

        // request while busy is dropped
        run_req(1'b0, 2, 3, 1'b1, 0, 3);
        check("busy_pulses", 72'(np), 72'd2);
        check("busy_other", 72'(other), 72'd0);
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.delay_line_move != '0) cnt++;
        end
        check("busy_idle", 72'(cnt), 72'd0);
        cur_of(2, cv);
        check("busy_cur2", 72'(cv), 72'd3);
        cur_of(5, cv);
        check("busy_cur5", 72'(cv), 72'd1);

        // reset during GAP aborts the move
        bus.dly_req    = 1'b1;
        bus.dly_load   = 1'b0;
        bus.dly_ch     = 4'd0;
        bus.dly_target = 9'd5;
        @(negedge clk);
        bus.dly_req = 1'b0;
        check("rg_first", 72'(bus.delay_line_move), 72'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int t = 0; t < 30; t++) begin
            if ((bus.delay_line_move | bus.delay_line_load) != '0) cnt++;
            @(negedge clk);
        end
        check("rg_pulses", 72'(cnt), 72'd0);
        check("rg_ready", 72'(bus.dly_ready), 72'd1);
        cur_of(0, cv);
        check("rg_cur0", 72'(cv), 72'd1);
        cur_of(2, cv);
        check("rg_cur2", 72'(cv), 72'd1);
        cur_of(3, cv);
        check("rg_cur3", 72'(cv), 72'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
